gp0_cmd_unpack: RTL and testbench
=================================

GP0_CMD_UNPACK -- requirements
Module: gp0_cmd_unpack

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: fifo_data  in  32  head word of upstream 16x32 command FIFO, valid whenever fifo_empty=0.
REQ-004 SHALL have ports: fifo_empty  in  1  upstream FIFO empty flag.
REQ-005 SHALL have ports: fifo_re  out  1  pop request; the FIFO pops at the same clock edge it is sampled.
REQ-006 SHALL have ports: cmd_valid  out  1  assembled command available.
REQ-007 SHALL have ports: cmd_ready  in  1  downstream accepts command.
REQ-008 SHALL have ports: cmd_op  out  8  opcode, header bits 31:24.
REQ-009 SHALL have ports: cmd_len  out  4  word count 1..12, header included.
REQ-010 SHALL have ports: cmd_words  out  12x32  word 0 = header, words in arrival order.
REQ-011 SHALL have ports: busy  out  1  high in any state other than HEADER.
REQ-012 SHALL have ports: unsup  out  1  one-cycle pulse on discard of an unsupported header.

Function
REQ-013 SHALL use a 3-state FSM: HEADER (await opcode), PARAMS (collect words), EMIT (present command).
REQ-014 SHALL drive fifo_re = !fifo_empty in HEADER and PARAMS, and fifo_re = 0 in EMIT; a word is consumed only when fifo_re=1.
REQ-015 SHALL compute length from the header: polygon 0x20-0x3F: n = 3 + bit27; len = 1 + n*(1+bit26) + (n-1)*bit28.
REQ-016 SHALL compute length from the header: line 0x40-0x5F with bit27=0: len = 3 + bit28.
REQ-017 SHALL compute length from the header: rect 0x60-0x7F: len = 2 + bit26 + (bits28:27==0).
REQ-018 SHALL compute length from the header: 0x02: len 3; 0x01 and 0xE1-0xE6: len 1.
REQ-019 SHALL discard 0x00 silently: word popped, no emit, no unsup pulse, FSM stays in HEADER.
REQ-020 SHALL discard all other opcodes, including polylines (0x40-0x5F with bit27=1) and 0x80-0xDF: one word popped, unsup=1 for the next cycle, FSM stays in HEADER.
REQ-021 SHALL, on header consume, store the word in words[0], zero words[1..11], latch op/len, set count=1, and go to EMIT if len=1, otherwise to PARAMS.
REQ-022 SHALL, in PARAMS, store each consumed word at words[count] and increment count; when the consumed word makes count+1 = len, go to EMIT next cycle.
REQ-023 SHALL hold the FSM in its state with no change when fifo_empty=1 in HEADER or PARAMS; gaps between words are unbounded.
REQ-024 SHALL assert cmd_valid only in EMIT, with cmd_op, cmd_len, cmd_words stable until the handshake.
REQ-025 SHALL return to HEADER on the edge where cmd_valid & cmd_ready = 1; cmd_valid deasserts on the following cycle.
REQ-026 SHALL meet latency: last word consumed at edge N -> cmd_valid=1 in cycle N+1; sustained rate of len+1 cycles per command with no stalls.
REQ-027 SHALL keep count 4 bits wide; count never exceeds 11.

Reset
REQ-028 SHALL, with rst=1 at an edge, set FSM to HEADER, count to 0, cmd_words to 0, cmd_op to 0, cmd_len to 0; cmd_valid, unsup, busy = 0; fifo_re = 0 while rst=1.
REQ-029 SHALL abandon a partially collected or unaccepted command on reset with no emit; words already popped are not recovered.

Structure
REQ-030 SHALL place the FSM state enum, the constant GP0_MAX_WORDS=12, and the opcode range constants in shared package gpu_cmd_pkg.
REQ-031 SHALL implement the combinational sub-module gp0_cmd_len (header in -> len, supported, silent) and instantiate it once.

Verification
REQ-032 SHALL cover: push 0xE1000123 -> cmd_valid one cycle after pop, op=0xE1, len=1, words[0]=0xE1000123, words[1..11]=0.
REQ-033 SHALL cover: push 0x3E000000 plus 11 words back-to-back -> 12 pops in 12 cycles, cmd_valid on cycle 13, len=12.
REQ-034 SHALL cover: push 0x60FF0000, 0x00100010, 0x00200020 with FIFO empty for 5 cycles between words -> len=3, no early valid, words in order.
REQ-035 SHALL cover: push 0x00000000, 0x48000000, 0x02000000 + 2 words -> NOP no pulse, one unsup pulse, then fill emitted with len=3.
REQ-036 SHALL cover: hold cmd_ready=0 for 10 cycles during EMIT with a FIFO that is not empty -> fifo_re=0 and outputs stable throughout, pop resumes the cycle after the handshake.
REQ-037 SHALL cover: assert rst in PARAMS after 2 of 4 words -> cmd_valid=0, busy=0, next header parsed fresh.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// GP0 command unpacker shared types.
// FSM states, word limits and opcode ranges.
package gpu_cmd_pkg;

  localparam int GP0_MAX_WORDS = 12;
  localparam int GP0_CNT_W     = 4;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_CLRC    = 8'h01;
  localparam logic [7:0] OP_FILL    = 8'h02;
  localparam logic [7:0] OP_POLY_LO = 8'h20;
  localparam logic [7:0] OP_POLY_HI = 8'h3F;
  localparam logic [7:0] OP_LINE_LO = 8'h40;
  localparam logic [7:0] OP_LINE_HI = 8'h5F;
  localparam logic [7:0] OP_RECT_LO = 8'h60;
  localparam logic [7:0] OP_RECT_HI = 8'h7F;
  localparam logic [7:0] OP_ENV_LO  = 8'hE1;
  localparam logic [7:0] OP_ENV_HI  = 8'hE6;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_PARAMS,
    ST_EMIT
  } gp0_state_e;

  function automatic logic in_range(
    input logic [7:0] op,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (op >= lo) && (op <= hi);
  endfunction

endpackage

// File: rtl/gp0_cmd_len.sv
// GP0 header decoder: opcode byte to word count.
// Flags NOP as silent and anything unknown as unsupported.
module gp0_cmd_len
  import gpu_cmd_pkg::*;
(
  input  logic [7:0] op,
  output logic [3:0] len,
  output logic       supported,
  output logic       silent
);

  logic [3:0] n;
  logic [3:0] pts;
  logic [3:0] links;

  assign n     = 4'd3 + {3'd0, op[3]};
  assign pts   = op[2] ? {n[2:0], 1'b0} : n;
  assign links = op[4] ? (n - 4'd1) : 4'd0;

  // classify the opcode and derive its total word count
  always_comb begin
    len       = 4'd1;
    supported = 1'b0;
    silent    = 1'b0;
    unique case (1'b1)
      (op == OP_NOP): begin
        silent = 1'b1;
      end
      (op == OP_CLRC),
      in_range(op, OP_ENV_LO, OP_ENV_HI): begin
        supported = 1'b1;
        len       = 4'd1;
      end
      (op == OP_FILL): begin
        supported = 1'b1;
        len       = 4'd3;
      end
      in_range(op, OP_POLY_LO, OP_POLY_HI): begin
        supported = 1'b1;
        len       = 4'd1 + pts + links;
      end
      (in_range(op, OP_LINE_LO, OP_LINE_HI) && !op[3]): begin
        supported = 1'b1;
        len       = 4'd3 + {3'd0, op[4]};
      end
      in_range(op, OP_RECT_LO, OP_RECT_HI): begin
        supported = 1'b1;
        len       = 4'd2 + {3'd0, op[2]}
                  + {3'd0, (op[4:3] == 2'b00)};
      end
      default: begin
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/gp0_cmd_unpack.sv
// GP0 command unpacker: pops FIFO words and
// assembles whole commands for a valid/ready sink.
module gp0_cmd_unpack
  import gpu_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_re,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [3:0]  cmd_len,
  output logic [GP0_MAX_WORDS-1:0][31:0] cmd_words,
  output logic        busy,
  output logic        unsup
);

  gp0_state_e           state;
  logic [GP0_CNT_W-1:0] count;
  logic [3:0]           hl_len;
  logic                 hl_sup;
  logic                 hl_sil;

  gp0_cmd_len u_len (
    .op        (fifo_data[31:24]),
    .len       (hl_len),
    .supported (hl_sup),
    .silent    (hl_sil)
  );

  assign fifo_re   = !rst && !fifo_empty
                   && (state != ST_EMIT);
  assign cmd_valid = (state == ST_EMIT);
  assign busy      = (state != ST_HEADER);

  // header parse, word collection and emit handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HEADER;
      count     <= '0;
      cmd_words <= '0;
      cmd_op    <= '0;
      cmd_len   <= '0;
      unsup     <= 1'b0;
    end else begin
      unsup <= 1'b0;
      unique case (state)
        ST_HEADER: begin
          if (fifo_re) begin
            if (hl_sup) begin
              cmd_words <= {{(GP0_MAX_WORDS-1)*32{1'b0}},
                            fifo_data};
              cmd_op    <= fifo_data[31:24];
              cmd_len   <= hl_len;
              count     <= 4'd1;
              state     <= (hl_len == 4'd1) ? ST_EMIT
                                            : ST_PARAMS;
            end else begin
              unsup <= !hl_sil;
            end
          end
        end
        ST_PARAMS: begin
          if (fifo_re) begin
            cmd_words[count] <= fifo_data;
            if (count + 4'd1 == cmd_len) begin
              state <= ST_EMIT;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (cmd_ready) begin
            state <= ST_HEADER;
            count <= '0;
          end
        end
        default: begin
          state <= ST_HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp0_cmd_unpack.sv
// Directed bench for gp0_cmd_unpack with a FIFO
// model and a scoreboard of expected commands.
module tb_gp0_cmd_unpack;
  import gpu_cmd_pkg::*;

  typedef struct packed {
    logic [7:0]        op;
    logic [3:0]        len;
    logic [11:0][31:0] words;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_re;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [11:0][31:0] cmd_words;
  logic        busy;
  logic        unsup;

  logic [31:0] mem [256];
  logic [7:0]  rd = 8'd0;
  logic [7:0]  wr = 8'd0;
  logic [7:0]  rd0;
  logic        gate = 1'b0;

  exp_t sb[$];
  exp_t cur;
  int   cur_n;
  int   vectors = 0;
  int   miscompares = 0;

  gp0_cmd_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_words  (cmd_words),
    .busy       (busy),
    .unsup      (unsup)
  );

  always #5 clk = ~clk;

  assign fifo_data  = mem[rd];
  assign fifo_empty = (rd == wr) || gate;

  always @(posedge clk) begin
    if (fifo_re) rd <= rd + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [383:0] obs,
    input logic [383:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr] = w;
    wr = wr + 8'd1;
  endtask

  task automatic start_cmd(input logic [3:0] l);
    cur = '0;
    cur.len = l;
    cur_n = 0;
  endtask

  task automatic add_word(input logic [31:0] w);
    cur.words[cur_n] = w;
    cur_n++;
    push_word(w);
  endtask

  task automatic end_cmd();
    cur.op = cur.words[0][31:24];
    sb.push_back(cur);
  endtask

  task automatic wait_cmd(input string tag, input int exp_n);
    int   n;
    exp_t e;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, exp_n);
    chk({tag, ".sb"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".op"}, cmd_op, e.op);
      chk({tag, ".len"}, cmd_len, e.len);
      chk({tag, ".words"}, cmd_words, e.words);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset with a word already waiting
    start_cmd(4'd1);
    add_word(32'hE1000123);
    end_cmd();
    repeat (2) tick();
    chk("rst.fifo_re", fifo_re, 0);
    chk("rst.valid", cmd_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.unsup", unsup, 0);
    chk("rst.op", cmd_op, 0);
    chk("rst.len", cmd_len, 0);
    chk("rst.words", cmd_words, 0);
    chk("rst.nopop", rd, 0);
    rst = 1'b0;

    // single-word command
    wait_cmd("t1", 1);
    tick();
    chk("t1.drop", {cmd_valid, busy}, 2'b00);

    // longest polygon, back to back
    start_cmd(4'd12);
    add_word(32'h3E000000);
    for (int i = 1; i < 12; i++)
      add_word(32'h10000000 + i * 32'h00010001);
    end_cmd();
    rd0 = rd;
    wait_cmd("t2", 12);
    chk("t2.pops", rd - rd0, 12);
    tick();

    // rectangle with 5-cycle gaps
    gate = 1'b1;
    start_cmd(4'd3);
    add_word(32'h60FF0000);
    add_word(32'h00100010);
    add_word(32'h00200020);
    end_cmd();
    for (int k = 0; k < 3; k++) begin
      gate = 1'b0;
      tick();
      gate = 1'b1;
      if (k < 2) begin
        repeat (5) tick();
        chk("t3.noearly", {cmd_valid, busy}, 2'b01);
      end
    end
    wait_cmd("t3", 0);
    gate = 1'b0;
    tick();

    // NOP, polyline discard, then fill
    push_word(32'h00000000);
    push_word(32'h48000000);
    start_cmd(4'd3);
    add_word(32'h02000000);
    add_word(32'h00123456);
    add_word(32'h00200010);
    end_cmd();
    tick();
    chk("t4.nop_unsup", unsup, 0);
    chk("t4.nop_busy", busy, 0);
    tick();
    chk("t4.unsup", unsup, 1);
    chk("t4.unsup_busy", busy, 0);
    tick();
    chk("t4.unsup_clr", unsup, 0);
    chk("t4.fill_busy", busy, 1);
    wait_cmd("t4", 2);
    tick();

    // backpressure with more words queued
    cmd_ready = 1'b0;
    start_cmd(4'd1);
    add_word(32'hE2000005);
    end_cmd();
    start_cmd(4'd3);
    add_word(32'h60000000);
    add_word(32'h00050005);
    add_word(32'h00030003);
    end_cmd();
    rd0 = rd;
    wait_cmd("t5a", 1);
    repeat (10) begin
      tick();
      chk("t5.hold",
          {fifo_re, cmd_valid, cmd_op, cmd_len},
          {1'b0, 1'b1, 8'hE2, 4'd1});
      chk("t5.words", cmd_words, 384'hE2000005);
    end
    chk("t5.nopop", rd - rd0, 1);
    cmd_ready = 1'b1;
    tick();
    chk("t5.resume", {cmd_valid, fifo_re}, 2'b01);
    chk("t5.resume_rd", rd - rd0, 1);
    wait_cmd("t5b", 3);
    tick();

    // reset mid-collection
    push_word(32'h20000000);
    push_word(32'h0000AAAA);
    tick();
    tick();
    chk("t6.params", {busy, cmd_valid}, 2'b10);
    rst = 1'b1;
    tick();
    chk("t6.rst",
        {busy, cmd_valid, unsup, cmd_len, cmd_op}, 0);
    chk("t6.rst_words", cmd_words, 0);
    rst = 1'b0;
    start_cmd(4'd1);
    add_word(32'hE3000042);
    end_cmd();
    wait_cmd("t6", 1);
    tick();

    chk("end.sb", sb.size(), 0);
    chk("end.idle", {cmd_valid, busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
